// File: rtl/boolean_exp.sv
// boolean_exp: registered (a&b)|c, a^b^c and majority of three inputs.
// Define BOOLEAN_EXP_SYNC_EN to add a SYNC_STAGES-deep input synchronizer per input.
module boolean_exp #(
    parameter logic [2:0] F_RESET     = 3'b000,
    parameter int         SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic f1,
    output logic f2,
    output logic f3
);
    logic       a_s, b_s, c_s;
    logic [2:0] f_d, f_q;
`ifdef BOOLEAN_EXP_SYNC_EN
    logic [SYNC_STAGES-1:0] a_q, b_q, c_q;
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_depth
        $error("SYNC_STAGES must be in 2..4");
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
        end else begin
            a_q <= {a_q[SYNC_STAGES-2:0], a};
            b_q <= {b_q[SYNC_STAGES-2:0], b};
            c_q <= {c_q[SYNC_STAGES-2:0], c};
        end
    end
    assign a_s = a_q[SYNC_STAGES-1];
    assign b_s = b_q[SYNC_STAGES-1];
    assign c_s = c_q[SYNC_STAGES-1];
`else
    assign a_s = a;
    assign b_s = b;
    assign c_s = c;
`endif
    always_comb begin
        f_d = {(a_s & b_s) | c_s, a_s ^ b_s ^ c_s, (a_s & b_s) | (a_s & c_s) | (b_s & c_s)};
    end
    always_ff @(posedge clk) begin
        if (!rst_n) f_q <= F_RESET;
        else        f_q <= f_d;
    end
    assign {f1, f2, f3} = f_q;
endmodule

// File: tb/tb_boolean_exp.sv
// tb_boolean_exp: directed checks of reset, truth table, reset priority and edge-only updates.
module tb_boolean_exp;
`ifdef BOOLEAN_EXP_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    logic clk = 1'b0;
    logic rst_n, a, b, c;
    logic f1, f2, f3;
    int total = 0;
    int fails = 0;
    logic [2:0] exp_tbl [8] = '{3'b000, 3'b110, 3'b010, 3'b101, 3'b010, 3'b101, 3'b101, 3'b111};

    boolean_exp dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
        .f1(f1), .f2(f2), .f3(f3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] exp);
        total++;
        assert ({f1, f2, f3} === exp)
        else begin
            fails++;
            $error("FAIL %s got %b expected %b", tag, {f1, f2, f3}, exp);
        end
    endtask

    task automatic apply(input string tag, input logic [2:0] abc, input logic [2:0] exp);
        {a, b, c} = abc;
        repeat (LAT) tick();
        chk(tag, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        {a, b, c} = 3'b111;
        tick();
        chk("reset_edge1", 3'b000);
        tick();
        chk("reset_edge2", 3'b000);
        rst_n = 1'b1;
        apply("seq_000", 3'b000, 3'b000);
        apply("seq_010", 3'b010, 3'b010);
        apply("seq_101", 3'b101, 3'b101);
        apply("seq_111", 3'b111, 3'b111);
        for (int i = 0; i < 8; i++) apply($sformatf("sweep_%0d", i), 3'(i), exp_tbl[i]);
        apply("pre_reset_111", 3'b111, 3'b111);
        rst_n = 1'b0;
        tick();
        chk("reset_wins", 3'b000);
        rst_n = 1'b1;
        apply("toggle_a1", 3'b100, 3'b010);
        #2 a = 1'b0;
        #2 chk("mid_cycle_a0", 3'b010);
        a = 1'b1;
        #2 chk("mid_cycle_a1", 3'b010);
        apply("toggle_a0", 3'b000, 3'b000);
`ifdef BOOLEAN_EXP_SYNC_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        {a, b, c} = 3'b110;
        tick();
        chk("sync_edge1", 3'b000);
        tick();
        chk("sync_edge2", 3'b000);
        tick();
        chk("sync_edge3", 3'b101);
`endif
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
